// File: rtl/bw_sram_arbiter.sv
// Round-robin arbiter that multiplexes three fixed-length burst requesters onto one SRAM port.
// Read beats carry their owner id through an RD_LAT-deep pipe so returns line up with mem_rdata.
module bw_sram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 1024,
    parameter int LEN_W  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  hold,
    input  logic [2:0]            req_valid,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [3*LEN_W-1:0]    req_len,
    output logic [2:0]            req_ready,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  wr_beat_ready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  rd_valid,
    output logic [1:0]            rd_id,
    output logic                  rd_last,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]                state_q, state_d;
    logic [1:0]                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]         base_q, base_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [LEN_W-1:0]          beat_q, beat_d;
    logic [1:0]                id_q, id_d;
    logic [RD_LAT-1:0]         pipe_v_q, pipe_v_d;
    logic [RD_LAT-1:0]         pipe_last_q, pipe_last_d;
    logic [RD_LAT-1:0][1:0]    pipe_id_q, pipe_id_d;

    logic       grant_any;
    logic [1:0] grant_idx;
    logic [1:0] cand;
    logic       beat_active;
    logic       is_write;
    logic       issue_rd;
    logic       last_beat;

    // Rotating search starting just after the previous winner; only possible while idle and not held.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = last_grant_q;
        cand      = last_grant_q;
        for (int k = 0; k < 3; k++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!grant_any && (state_q == ST_IDLE) && !hold && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        req_ready = grant_any ? (3'b001 << grant_idx) : 3'b000;
    end

    always_comb begin
        beat_active = (state_q == ST_BURST);
        is_write    = (id_q == 2'd0);
        last_beat   = (beat_q == len_q);
        issue_rd    = beat_active && !is_write;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        base_d       = base_q;
        len_d        = len_q;
        beat_d       = beat_q;
        id_d         = id_q;
        if (state_q == ST_IDLE) begin
            if (grant_any) begin
                state_d      = ST_BURST;
                last_grant_d = grant_idx;
                id_d         = grant_idx;
                beat_d       = '0;
                for (int i = 0; i < 3; i++) begin
                    if (grant_idx == 2'(i)) begin
                        base_d = req_addr[i*ADDR_W +: ADDR_W];
                        len_d  = req_len[i*LEN_W +: LEN_W];
                    end
                end
            end
        end else begin
            beat_d = beat_q + LEN_W'(1);
            if (last_beat) begin
                state_d = ST_IDLE;
            end
        end
    end

    // Each read beat pushes its owner and last flag; the oldest stage lines up with mem_rdata.
    always_comb begin
        pipe_v_d    = pipe_v_q;
        pipe_last_d = pipe_last_q;
        pipe_id_d   = pipe_id_q;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            pipe_v_d[i]    = pipe_v_q[i-1];
            pipe_last_d[i] = pipe_last_q[i-1];
            pipe_id_d[i]   = pipe_id_q[i-1];
        end
        pipe_v_d[0]    = issue_rd;
        pipe_last_d[0] = issue_rd && last_beat;
        pipe_id_d[0]   = issue_rd ? id_q : 2'd0;
    end

    always_comb begin
        mem_en        = beat_active;
        mem_we        = beat_active && is_write;
        wr_beat_ready = beat_active && is_write;
        mem_addr      = beat_active ? (base_q + ADDR_W'(beat_q)) : '0;
        mem_wdata     = (beat_active && is_write) ? wr_data : '0;
        rd_valid      = pipe_v_q[RD_LAT-1];
        rd_id         = pipe_id_q[RD_LAT-1];
        rd_last       = pipe_last_q[RD_LAT-1];
        rd_data       = pipe_v_q[RD_LAT-1] ? mem_rdata : '0;
        busy          = beat_active || (|pipe_v_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 2'd2;
            base_q       <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            id_q         <= '0;
            pipe_v_q     <= '0;
            pipe_last_q  <= '0;
            pipe_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            base_q       <= base_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            id_q         <= id_d;
            pipe_v_q     <= pipe_v_d;
            pipe_last_q  <= pipe_last_d;
            pipe_id_q    <= pipe_id_d;
        end
    end

endmodule

// File: tb/tb_bw_sram_arbiter.sv
// Self-checking bench for bw_sram_arbiter: two instances (RD_LAT 1 and 3) share stimulus and are
// compared every cycle against a schedule-based model that books whole bursts at grant time.
module tb_bw_sram_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 1024;
    localparam int LW   = 4;
    localparam int NCYC = 4096;

    logic              clk = 1'b0;
    logic              rstn;
    logic              hold;
    logic [2:0]        req_valid;
    logic [3*AW-1:0]   req_addr;
    logic [3*LW-1:0]   req_len;
    logic [DW-1:0]     wr_data;
    logic [DW-1:0]     mem_rdata_a, mem_rdata_b, sb1, sb2;

    logic [2:0]    a_req_ready, b_req_ready;
    logic          a_wbr, b_wbr, a_mem_en, b_mem_en, a_mem_we, b_mem_we;
    logic [AW-1:0] a_mem_addr, b_mem_addr;
    logic [DW-1:0] a_mem_wdata, b_mem_wdata, a_rd_data, b_rd_data;
    logic          a_rd_valid, b_rd_valid, a_rd_last, b_rd_last, a_busy, b_busy;
    logic [1:0]    a_rd_id, b_rd_id;

    bw_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(1)) dut_a (
        .clk(clk), .rstn(rstn), .hold(hold), .req_valid(req_valid), .req_addr(req_addr),
        .req_len(req_len), .req_ready(a_req_ready), .wr_data(wr_data), .wr_beat_ready(a_wbr),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(mem_rdata_a), .rd_valid(a_rd_valid), .rd_id(a_rd_id), .rd_last(a_rd_last),
        .rd_data(a_rd_data), .busy(a_busy)
    );

    bw_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(3)) dut_b (
        .clk(clk), .rstn(rstn), .hold(hold), .req_valid(req_valid), .req_addr(req_addr),
        .req_len(req_len), .req_ready(b_req_ready), .wr_data(wr_data), .wr_beat_ready(b_wbr),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata_b), .rd_valid(b_rd_valid), .rd_id(b_rd_id), .rd_last(b_rd_last),
        .rd_data(b_rd_data), .busy(b_busy)
    );

    always #5 clk = ~clk;

    // SRAM stand-ins: each word reads back as its own address replicated across the bus.
    always @(posedge clk) begin
        mem_rdata_a <= (a_mem_en && !a_mem_we) ? {64{a_mem_addr}} : '0;
        sb1         <= (b_mem_en && !b_mem_we) ? {64{b_mem_addr}} : '0;
        sb2         <= sb1;
        mem_rdata_b <= sb2;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int free_cyc = 0;
    int last_g = 2;
    int exp_g;
    logic [2:0] exp_ready;

    bit        pend [3];
    logic [15:0] paddr [3];
    logic [3:0]  plen [3];

    bit          e_en [NCYC];
    bit          e_we [NCYC];
    logic [15:0] e_addr [NCYC];
    bit          busy1 [NCYC];
    bit          busy3 [NCYC];
    bit          r1_v [NCYC];
    bit          r1_last [NCYC];
    logic [1:0]  r1_id [NCYC];
    logic [15:0] r1_addr [NCYC];
    bit          r3_v [NCYC];
    bit          r3_last [NCYC];
    logic [1:0]  r3_id [NCYC];

    int beats_seen, wbeats_seen, rv_seen, rvb_seen;
    logic [15:0] last_addr_seen;
    int gq[$];

    typedef struct {
        int          id;
        logic [15:0] addr;
        int          len;
        logic [15:0] exp_last_addr;
        int          exp_beats;
        int          exp_returns;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s cyc=%0d actual(low)=%h required(low)=%h", name, cyc,
                     act[127:0], exp[127:0]);
        end
    endtask

    task automatic post(input int r, input logic [15:0] addr, input int len);
        pend[r]  = 1'b1;
        paddr[r] = addr;
        plen[r]  = 4'(len);
    endtask

    // Books a whole burst (beats, read returns for both latencies, busy window) at grant time.
    task automatic model_eval();
        int c;
        int r;
        exp_g     = -1;
        exp_ready = 3'b000;
        if (!rstn) begin
            for (int i = cyc; i < NCYC; i++) begin
                e_en[i] = 0; e_we[i] = 0; e_addr[i] = '0; busy1[i] = 0; busy3[i] = 0;
                r1_v[i] = 0; r1_last[i] = 0; r1_id[i] = '0; r1_addr[i] = '0;
                r3_v[i] = 0; r3_last[i] = 0; r3_id[i] = '0;
            end
            free_cyc = cyc + 1;
            last_g   = 2;
        end else if (cyc >= free_cyc && !hold) begin
            for (int k = 1; k <= 3; k++) begin
                r = (last_g + k) % 3;
                if (exp_g < 0 && pend[r]) exp_g = r;
            end
        end
        if (exp_g >= 0) begin
            exp_ready = 3'(1 << exp_g);
            last_g    = exp_g;
            free_cyc  = cyc + 2 + int'(plen[exp_g]);
            for (int k = 0; k <= int'(plen[exp_g]); k++) begin
                c = cyc + 1 + k;
                e_en[c]   = 1;
                e_we[c]   = (exp_g == 0);
                e_addr[c] = paddr[exp_g] + 16'(k);
                busy1[c]  = 1;
                busy3[c]  = 1;
                if (exp_g != 0) begin
                    r1_v[c+1]    = 1;
                    r1_id[c+1]   = 2'(exp_g);
                    r1_last[c+1] = (k == int'(plen[exp_g]));
                    r1_addr[c+1] = e_addr[c];
                    busy1[c+1]   = 1;
                    r3_v[c+3]    = 1;
                    r3_id[c+3]   = 2'(exp_g);
                    r3_last[c+3] = (k == int'(plen[exp_g]));
                    for (int j = 1; j <= 3; j++) busy3[c+j] = 1;
                end
            end
        end
    endtask

    task automatic applyStimulus();
        if (!rstn) begin
            for (int r = 0; r < 3; r++) pend[r] = 0;
        end
        for (int r = 0; r < 3; r++) begin
            req_valid[r]          = pend[r];
            req_addr[r*AW +: AW]  = paddr[r];
            req_len[r*LW +: LW]   = plen[r];
        end
        for (int i = 0; i < DW/32; i++) wr_data[i*32 +: 32] = $urandom;
        model_eval();
    endtask

    task automatic checkOutput();
        logic [DW-1:0] exp_wd;
        logic [DW-1:0] exp_rd;
        exp_wd = e_we[cyc] ? wr_data : '0;
        exp_rd = r1_v[cyc] ? {64{r1_addr[cyc]}} : '0;
        chk("a_req_ready", 32'(a_req_ready), 32'(exp_ready));
        chk("a_mem_en", 32'(a_mem_en), 32'(e_en[cyc]));
        chk("a_mem_we", 32'(a_mem_we), 32'(e_we[cyc]));
        chk("a_wr_beat_ready", 32'(a_wbr), 32'(e_we[cyc]));
        chk("a_mem_addr", 32'(a_mem_addr), 32'(e_addr[cyc]));
        chk_wide("a_mem_wdata", a_mem_wdata, exp_wd);
        chk("a_rd_valid", 32'(a_rd_valid), 32'(r1_v[cyc]));
        chk("a_rd_id", 32'(a_rd_id), 32'(r1_id[cyc]));
        chk("a_rd_last", 32'(a_rd_last), 32'(r1_last[cyc]));
        chk_wide("a_rd_data", a_rd_data, exp_rd);
        chk("a_busy", 32'(a_busy), 32'(busy1[cyc]));
        chk("b_req_ready", 32'(b_req_ready), 32'(exp_ready));
        chk("b_mem_en", 32'(b_mem_en), 32'(e_en[cyc]));
        chk("b_mem_addr", 32'(b_mem_addr), 32'(e_addr[cyc]));
        chk("b_rd_valid", 32'(b_rd_valid), 32'(r3_v[cyc]));
        chk("b_rd_id", 32'(b_rd_id), 32'(r3_id[cyc]));
        chk("b_rd_last", 32'(b_rd_last), 32'(r3_last[cyc]));
        chk("b_busy", 32'(b_busy), 32'(busy3[cyc]));
        if (a_mem_en) begin
            beats_seen++;
            last_addr_seen = a_mem_addr;
        end
        if (a_mem_we) wbeats_seen++;
        if (a_rd_valid) rv_seen++;
        if (b_rd_valid) rvb_seen++;
        for (int i = 0; i < 3; i++) if (a_req_ready[i]) gq.push_back(i);
    endtask

    task automatic runCycle();
        applyStimulus();
        #2;
        checkOutput();
        @(negedge clk);
        cyc++;
        if (exp_g >= 0) pend[exp_g] = 0;
    endtask

    initial begin
        int g0;
        int rr_exp [4];
        bit reposted;

        vecs[0] = '{1, 16'h0100, 3,  16'h0103, 4,  4};
        vecs[1] = '{2, 16'hFFFE, 2,  16'h0000, 3,  3};
        vecs[2] = '{0, 16'h0020, 0,  16'h0020, 1,  0};
        vecs[3] = '{0, 16'h1234, 15, 16'h1243, 16, 0};
        vecs[4] = '{2, 16'hFFFF, 0,  16'hFFFF, 1,  1};
        rr_exp  = '{0, 1, 2, 0};

        for (int r = 0; r < 3; r++) begin
            pend[r] = 0; paddr[r] = '0; plen[r] = '0;
        end
        rstn = 1'b0;
        hold = 1'b0;
        repeat (3) runCycle();
        rstn = 1'b1;

        $display("[TB] round-robin from reset");
        post(0, 16'h0010, 0);
        post(1, 16'h0020, 0);
        post(2, 16'h0030, 0);
        g0 = gq.size();
        reposted = 0;
        repeat (12) begin
            runCycle();
            if (!reposted && !pend[0]) begin
                post(0, 16'h0040, 0);
                reposted = 1;
            end
        end
        chk("rr_grant_count", 32'(gq.size() - g0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (g0 + i < gq.size()) chk("rr_order", 32'(gq[g0+i]), 32'(rr_exp[i]));
            else chk("rr_order_missing", 32'(gq.size()), 32'(g0 + i + 1));
        end

        $display("[TB] single-burst vector table");
        for (int v = 0; v < 5; v++) begin
            beats_seen = 0;
            rv_seen    = 0;
            last_addr_seen = 16'h0;
            post(vecs[v].id, vecs[v].addr, vecs[v].len);
            repeat (24) runCycle();
            chk("tbl_beats", 32'(beats_seen), 32'(vecs[v].exp_beats));
            chk("tbl_last_addr", 32'(last_addr_seen), 32'(vecs[v].exp_last_addr));
            chk("tbl_returns", 32'(rv_seen), 32'(vecs[v].exp_returns));
        end

        $display("[TB] hold gating");
        post(1, 16'h0200, 2);
        hold = 1'b1;
        g0 = gq.size();
        repeat (5) runCycle();
        chk("hold_no_grant", 32'(gq.size()), 32'(g0));
        hold = 1'b0;
        runCycle();
        chk("hold_release_grant", 32'(gq.size()), 32'(g0 + 1));
        hold = 1'b1;
        post(2, 16'h0300, 0);
        beats_seen = 0;
        repeat (6) runCycle();
        chk("hold_mid_burst_beats", 32'(beats_seen), 32'd3);
        chk("hold_blocks_next", 32'(gq.size()), 32'(g0 + 1));
        hold = 1'b0;
        repeat (6) runCycle();
        chk("hold_then_req2", 32'(gq[$]), 32'd2);

        $display("[TB] long write with waiting reader");
        post(0, 16'h1000, 15);
        wbeats_seen = 0;
        runCycle();
        post(2, 16'h2000, 1);
        g0 = gq.size();
        repeat (16) runCycle();
        chk("long_write_beats", 32'(wbeats_seen), 32'd16);
        chk("long_write_no_grant", 32'(gq.size()), 32'(g0));
        runCycle();
        chk("turnaround_grant", 32'(gq.size()), 32'(g0 + 1));
        chk("turnaround_grant_id", 32'(gq[$]), 32'd2);
        repeat (8) runCycle();

        $display("[TB] reset mid-burst");
        post(1, 16'h0500, 7);
        runCycle();
        repeat (2) runCycle();
        rv_seen  = 0;
        rvb_seen = 0;
        rstn = 1'b0;
        runCycle();
        repeat (2) runCycle();
        rstn = 1'b1;
        repeat (8) runCycle();
        chk("rst_no_rd_valid_a", 32'(rv_seen), 32'd0);
        chk("rst_no_rd_valid_b", 32'(rvb_seen), 32'd0);
        g0 = gq.size();
        post(2, 16'h0400, 1);
        repeat (8) runCycle();
        chk("rst_regrant", 32'(gq.size()), 32'(g0 + 1));
        chk("rst_regrant_returns", 32'(rv_seen), 32'd2);

        $display("[TB] randomized traffic");
        repeat (1200) begin
            if (cyc > NCYC - 60) break;
            for (int r = 0; r < 3; r++) begin
                if (!pend[r] && $urandom_range(0, 3) == 0) begin
                    post(r, 16'($urandom),
                         ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                     : int'($urandom_range(0, 2)));
                end
            end
            hold = ($urandom_range(0, 7) == 0);
            runCycle();
        end
        hold = 1'b0;
        repeat (30) runCycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bw_sram_arbiter.md
# bw_sram_arbiter

Single-port SRAM arbiter for the BitWave accelerator. Three requesters share the one on-chip SRAM port: result write-back from the PE array, weight-column fetch and activation fetch for the Dispatcher. Requests are fixed-length bursts; the block arbitrates them round-robin, issues one beat per cycle and returns read data tagged with the requester ID. It replaces the per-requester address outputs, so only one SRAM access exists per cycle.

## Interface
Parameters:
- ADDR_W, 16, SRAM word address width.
- DATA_W, 1024, SRAM word width.
- LEN_W, 4, burst length field width; the field encodes beats−1, so 1..16 beats.
- RD_LAT, 1, SRAM read latency in cycles (legal 1..4).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- hold  in  1  when high, no new burst is granted; a burst already in progress completes.
- req_valid  in  3  per-requester request. Bit 0 = result write, bit 1 = weight read, bit 2 = activation read.
- req_addr  in  3×ADDR_W  burst base address, packed with requester i at [i*ADDR_W +: ADDR_W].
- req_len  in  3×LEN_W  beats−1, packed the same way.
- req_ready  out  3  one-hot acceptance pulse.
- wr_data  in  DATA_W  write beat data from requester 0.
- wr_beat_ready  out  1  high in a write-beat cycle; wr_data is consumed that cycle.
- mem_en, mem_we  out  1 each  SRAM enable and write strobe.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after the read issue.
- rd_valid  out  1  read-return valid.
- rd_id  out  2  read-return owner: 1 = weight, 2 = activation.
- rd_last  out  1  marks the final beat of a read burst.
- rd_data  out  DATA_W  read-return data (mem_rdata passed through).
- busy  out  1  high while the FSM is in BURST or read beats are still in flight.

## Operation
- FSM states: IDLE and BURST.
- In IDLE with hold=0 and any req_valid set, the block grants one requester:
  - Priority search starts at last_grant+1 mod 3.
  - It pulses req_ready[g] for that cycle, latches base address, length and id, sets last_grant=g, then moves to BURST.
- req_ready is never asserted without the matching req_valid. A requester holds valid, addr and len stable until it sees ready.
- In BURST, beat k (k = 0..len) is issued each cycle:
  - mem_en=1 and mem_addr = base+k modulo 2^ADDR_W; addresses wrap from 0xFFFF to 0x0000.
  - For a write burst (id 0): mem_we=1, wr_beat_ready=1, mem_wdata=wr_data combinationally.
  - For a read burst: mem_we=0, and id plus a last flag enter an RD_LAT-deep pipe.
- After beat len, the FSM returns to IDLE, so every burst has exactly one arbitration/turnaround cycle.
- rd_valid, rd_id and rd_last emerge from the pipe aligned with mem_rdata. rd_data = mem_rdata.
- Bursts cannot be preempted. hold and req_valid changes during BURST have no effect.
- hold only gates the grant in IDLE. If hold and a request arrive in the same cycle, the request is not granted.
- Outside write beats, mem_wdata = 0. Outside beat cycles, mem_en = mem_we = 0 and mem_addr = 0.

## Timing
- Reset values: state IDLE, last_grant=2 (so the first search starts at requester 0), read pipe cleared. Every output is 0: req_ready, mem_en, mem_we, mem_addr, mem_wdata, wr_beat_ready, rd_valid, rd_id, rd_last, rd_data, busy.
- Grant at cycle t → beat 0 at t+1 → beat len at t+1+len → IDLE at t+2+len → next grant possible at t+2+len.
- A burst of N beats occupies N+1 cycles, so peak throughput is N/(N+1).
- For a read beat issued at cycle c, rd_valid is high at cycle c+RD_LAT. rd_last accompanies the return of beat len.
- busy rises the cycle after a grant. It falls after the last rd_valid, or after the last write beat.
- Reset asserted mid-burst: all state and the read pipe clear asynchronously. No rd_valid appears after reset, and the interrupted burst is dropped without resumption.
- req_ready is registered-state-driven (combinational from state plus req_valid) and has no combinational path from rd_* signals.

## Test plan
- Single weight read, addr 0x0100, len 3, RD_LAT=1 → req_ready[1] at t; mem_addr 0x100–0x103 at t+1..t+4; rd_valid at t+2..t+5 with rd_id=1 and rd_last only at t+5.
- All three requesting from reset, each with len 0 → grants 0, 1, 2, 0 on successive grant cycles spaced 2 cycles apart; beat 0 of the write has mem_we=1 and mem_wdata=wr_data.
- Activation read at 0xFFFE, len 2 → mem_addr 0xFFFE, 0xFFFF, 0x0000; rd_id=2.
- hold=1 for 5 cycles with req_valid=3'b010 → no req_ready and mem_en=0. Grant occurs the cycle hold drops. hold raised mid-burst → the burst completes all beats.
- Write burst len 15 while requester 2 is waiting → 16 consecutive write beats with no read interleaved, then requester 2 granted at the turnaround cycle.
- rstn pulsed low at beat 2 of a len-7 read with RD_LAT=3 → all outputs 0 immediately; no rd_valid afterwards; a new request is granted normally after reset release.
